// File: rtl/uart_rx_frontend.sv
// uart_rx_frontend: 16x-oversampling 8N1 serial receiver with idle timeout.
//
// Ports:
//   clk        system clock; every flop is clocked on the rising edge
//   reset_n    asynchronous active-low reset
//   rxd        raw serial line (idle high, asynchronous to clk)
//   rx_data    last correctly framed byte (LSB received first), held until next rx_done
//   rx_done    one-cycle strobe: new byte on rx_data
//   timeout    one-cycle strobe: line idle TIMEOUT_BITS bit-times after the last rx_done
//   frame_err  one-cycle strobe: stop bit sampled low
//   busy       high while the receive FSM is not idle
//
// Optional build macro RX_MAJORITY_EN: each bit decision takes a 2-of-3 majority of the
// samples at phases 6, 7 and 8, and the decision is made at phase 8 rather than phase 7.

module uart_rx_frontend #(
    parameter int unsigned CLK_FREQ     = 50_000_000,
    parameter int unsigned BAUD         = 115200,
    parameter int unsigned TIMEOUT_BITS = 32,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_done,
    output logic       timeout,
    output logic       frame_err,
    output logic       busy
);

    // Rounded oversample divider, clamped to at least 1.
    localparam int unsigned DIV_RAW = (CLK_FREQ + 8 * BAUD) / (16 * BAUD);
    localparam int unsigned DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int unsigned DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(DIV - 1);
    localparam logic [7:0]       TO_LIMIT = 8'(TIMEOUT_BITS - 1);

    typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rs_prev_q;
    logic [DIV_W-1:0]       div_q, div_d;
    logic [3:0]             phase_q, phase_d;
    logic [2:0]             bit_idx_q, bit_idx_d;
    logic                   last_bit_q, last_bit_d;
    logic [7:0]             shift_q, shift_d;
    logic [7:0]             rx_data_q, rx_data_d;
    logic                   rx_done_q, rx_done_d;
    logic                   frame_err_q, frame_err_d;
    logic                   timeout_q, timeout_d;
    logic                   to_armed_q, to_armed_d;
    logic [3:0]             to_sub_q, to_sub_d;
    logic [7:0]             to_cnt_q, to_cnt_d;

    logic rs;
    logic start_edge;
    logic tick;
    logic sample_evt;
    logic sample_bit;

    assign rs         = sync_q[SYNC_STAGES-1];
    assign start_edge = (state_q == StIdle) && rs_prev_q && !rs;
    assign tick       = (div_q == DIV_MAX);

`ifdef RX_MAJORITY_EN
    logic [1:0] maj_q, maj_d;

    always_comb begin
        maj_d = maj_q;
        if (tick && (phase_q == 4'd6)) maj_d[0] = rs;
        if (tick && (phase_q == 4'd7)) maj_d[1] = rs;
    end

    // Third vote is the live sample at phase 8.
    assign sample_evt = tick && (phase_q == 4'd8);
    assign sample_bit = (maj_q[0] & maj_q[1]) | (maj_q[0] & rs) | (maj_q[1] & rs);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            maj_q <= 2'b11;
        end else begin
            maj_q <= maj_d;
        end
    end
`else
    assign sample_evt = tick && (phase_q == 4'd7);
    assign sample_bit = rs;
`endif

    // Divider and phase restart on the start edge so sampling lines up with the bit centre.
    always_comb begin
        div_d   = div_q + DIV_W'(1);
        phase_d = phase_q;
        if (tick) begin
            div_d   = '0;
            phase_d = phase_q + 4'd1;
        end
        if (start_edge) begin
            div_d   = '0;
            phase_d = '0;
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_idx_d   = bit_idx_q;
        last_bit_d  = last_bit_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        rx_done_d   = 1'b0;
        frame_err_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_edge) state_d = StStart;
            end
            StStart: begin
                if (sample_evt) begin
                    if (!sample_bit) begin
                        state_d    = StData;
                        bit_idx_d  = 3'd0;
                        last_bit_d = 1'b0;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StData: begin
                if (last_bit_q) begin
                    // All eight bits taken; move on at the bit boundary.
                    if (tick && (phase_q == 4'd15)) state_d = StStop;
                end else if (sample_evt) begin
                    shift_d   = {sample_bit, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) last_bit_d = 1'b1;
                end
            end
            StStop: begin
                if (sample_evt) begin
                    if (sample_bit) begin
                        rx_data_d = shift_q;
                        rx_done_d = 1'b1;
                        state_d   = StIdle;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = StBreak;
                    end
                end
            end
            StBreak: begin
                if (rs) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Idle timeout: counts whole bit-times (16 ticks) from the arming rx_done.
    always_comb begin
        to_armed_d = to_armed_q;
        to_sub_d   = to_sub_q;
        to_cnt_d   = to_cnt_q;
        timeout_d  = 1'b0;
        if (rx_done_d) begin
            to_armed_d = 1'b1;
            to_sub_d   = '0;
            to_cnt_d   = '0;
        end else if (frame_err_d) begin
            to_armed_d = 1'b0;
        end else if (start_edge) begin
            to_sub_d = '0;
            to_cnt_d = '0;
        end else if (to_armed_q && (state_q == StIdle) && tick) begin
            to_sub_d = to_sub_q + 4'd1;
            if (to_sub_q == 4'd15) begin
                if (to_cnt_q == TO_LIMIT) begin
                    timeout_d  = 1'b1;
                    to_armed_d = 1'b0;
                end else begin
                    to_cnt_d = to_cnt_q + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q      <= '1;
            rs_prev_q   <= 1'b1;
            state_q     <= StIdle;
            div_q       <= '0;
            phase_q     <= '0;
            bit_idx_q   <= '0;
            last_bit_q  <= 1'b0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rx_done_q   <= 1'b0;
            frame_err_q <= 1'b0;
            timeout_q   <= 1'b0;
            to_armed_q  <= 1'b0;
            to_sub_q    <= '0;
            to_cnt_q    <= '0;
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], rxd};
            rs_prev_q   <= rs;
            state_q     <= state_d;
            div_q       <= div_d;
            phase_q     <= phase_d;
            bit_idx_q   <= bit_idx_d;
            last_bit_q  <= last_bit_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_done_q   <= rx_done_d;
            frame_err_q <= frame_err_d;
            timeout_q   <= timeout_d;
            to_armed_q  <= to_armed_d;
            to_sub_q    <= to_sub_d;
            to_cnt_q    <= to_cnt_d;
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_done   = rx_done_q;
    assign frame_err = frame_err_q;
    assign timeout   = timeout_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: doc/uart_rx_frontend.md
Name: uart_rx_frontend

Overview:
- Serial receiver directly upstream of the UART packet-assembly stage.
- Oversamples the asynchronous rxd line at 16x baud and deframes 8N1 characters.
- Presents each byte as rx_data plus a one-cycle rx_done strobe.
- Generates the inter-byte idle timeout pulse that the packet stage uses to abort partial packets.

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz.
- BAUD, 115200, line rate in bit/s. Oversample divider DIV = round(CLK_FREQ/(16*BAUD)), must be >= 1.
- TIMEOUT_BITS, 32, idle bit-times after the last good byte before timeout fires. Range 1..255.
- SYNC_STAGES, 2, number of rxd synchroniser flops, >= 2.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- rxd  in  1  raw serial line, idle high, asynchronous to clk.
- rx_data  out  8  last correctly framed byte, LSB received first.
- rx_done  out  1  one-cycle strobe: new byte on rx_data.
- timeout  out  1  one-cycle strobe: line idle TIMEOUT_BITS bit-times after the last rx_done.
- frame_err  out  1  one-cycle strobe: stop bit sampled low.
- busy  out  1  high while the FSM is not in IDLE.

Behaviour:
- Reset values:
  - rx_data=0x00; rx_done=0, timeout=0, frame_err=0, busy=0.
  - FSM in IDLE; timeout counter disarmed.
  - Synchroniser flops reset to 1.
- rxd passes through SYNC_STAGES flops. All decisions use the synchronised value rs.
- Tick divider: counts 0..DIV-1 and produces a one-cycle tick at DIV-1. It is forced to 0 on start-edge detection so sampling is aligned to the edge.
- Phase counter (4 bits) advances on each tick. Phase 7 is the mid-bit sample point. Wraps 15 -> 0 at the bit boundary.
- FSM states:
  - IDLE: rs falling edge (previous=1, current=0) -> START; clear phase and divider.
  - START: at phase 7, rs=0 -> DATA with bit index 0; rs=1 -> IDLE (false start, no strobe).
  - DATA: at phase 7, shift rs into a shift register MSB side, so LSB arrives first. After bit index 7 is sampled, wait until the phase-15 tick -> STOP.
  - STOP: at phase 7:
    - rs=1: rx_data <= shift register and rx_done=1 in the next cycle; then -> IDLE.
    - rs=0: frame_err=1 in the next cycle; rx_data is unchanged, no rx_done; -> BREAK.
  - BREAK: remain until rs=1, then -> IDLE. A falling edge is not detected until rs has been high for at least one cycle.
- rx_data:
  - Is updated on the same edge that raises rx_done.
  - Holds until the next rx_done, so a consumer may sample it any number of cycles after the strobe.
- Latency: rx_done rises (SYNC_STAGES + 1) cycles + 9.5 bit-times +/- 1 tick after the rxd falling edge of the start bit.
- Timeout:
  - Armed and counter cleared on every rx_done.
  - While armed and in IDLE, the counter increments once per bit-time (every 16 ticks).
  - Reaching TIMEOUT_BITS gives timeout=1 for one cycle, then the counter disarms. It never repeats until rearmed.
  - A start edge clears the counter but keeps it armed. A false start therefore restarts the idle count.
  - frame_err disarms the timer.
- Simultaneous events:
  - rx_done and timeout never coincide, since timeout requires IDLE after an arm.
  - frame_err and rx_done are mutually exclusive.
- Reset mid-frame: immediate return to reset values. The partial byte is discarded, with no strobe on reset release.
- Strobes are registered outputs, glitch-free.

Optional Feature:
- RX_MAJORITY_EN
  - Defined: each START/DATA/STOP decision uses a 2-of-3 majority of rs captured at phases 6, 7, 8, and the decision is taken at phase 8. Latency grows by 1 tick.
  - Undefined: single sample at phase 7; no extra flops.

Test Plan:
- Byte decode. Use CLK_FREQ=1_843_200, BAUD=115200 (DIV=1). Send 0xA5 8N1 -> one rx_done pulse, rx_data=0xA5, frame_err=0, busy low after the stop mid-sample.
- Back-to-back bytes. Send 0x00, 0xFF, 0x3C with zero gap -> three rx_done pulses in order with those values; no timeout between them.
- Framing error. Send 0x55 with stop bit=0, hold the line low 20 bit-times, then release -> frame_err one pulse, no rx_done, rx_data still holds the prior value, no timeout; the next 0x12 decodes correctly.
- False start. Pulse rxd low for 4 oversample ticks -> no rx_done, no frame_err, FSM back in IDLE by phase 8.
- Timeout. With TIMEOUT_BITS=32, send 0x01 and then idle -> timeout exactly one pulse 32 bit-times +/- 1 tick after rx_done, and none thereafter. Repeat with a byte at 20 bit-times -> timeout fires 32 bit-times after that byte instead.
- Reset mid-frame. Assert reset_n=0 during DATA bit 4 of 0xC3 -> outputs at reset values. After release, a full 0x7E decodes correctly, with no spurious strobe. With RX_MAJORITY_EN, a one-tick glitch at phase 7 of each bit does not corrupt 0x7E.
